// File: rtl/dual_bus_arbiter_if.sv
// Bundled signals of the two requesting masters and the shared memory port.
// The arbiter connects through the slave modport; stimulus drives the master modport.
interface dual_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  instr_cyc;
    logic                  instr_stb;
    logic                  instr_we;
    logic [3:0]            instr_wstrb;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic [DATA_WIDTH-1:0] instr_data_out;
    logic [DATA_WIDTH-1:0] instr_data_in;
    logic                  instr_ack;

    logic                  data_cyc;
    logic                  data_stb;
    logic                  data_we;
    logic [3:0]            data_wstrb;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [DATA_WIDTH-1:0] data_data_out;
    logic [DATA_WIDTH-1:0] data_data_in;
    logic                  data_ack;

    logic                  mem_cyc;
    logic                  mem_stb;
    logic                  mem_we;
    logic [3:0]            mem_wstrb;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_ack;

    modport slave (
        input  instr_cyc, instr_stb, instr_we, instr_wstrb, instr_addr, instr_data_out,
        output instr_data_in, instr_ack,
        input  data_cyc, data_stb, data_we, data_wstrb, data_addr, data_data_out,
        output data_data_in, data_ack,
        output mem_cyc, mem_stb, mem_we, mem_wstrb, mem_addr, mem_data_out,
        input  mem_data_in, mem_ack
    );

    modport master (
        output instr_cyc, instr_stb, instr_we, instr_wstrb, instr_addr, instr_data_out,
        input  instr_data_in, instr_ack,
        output data_cyc, data_stb, data_we, data_wstrb, data_addr, data_data_out,
        input  data_data_in, data_ack,
        input  mem_cyc, mem_stb, mem_we, mem_wstrb, mem_addr, mem_data_out,
        output mem_data_in, mem_ack
    );
endinterface

// File: rtl/dual_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction and a data master,
// with a stall timeout that completes the owner's request with zero data and flags bus_err.
module dual_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_bus_arbiter_if.slave     bus,
    output logic                  bus_err,
    output logic                  err_src
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [15:0] TO_LIMIT = TIMEOUT_CYCLES[15:0];

    state_t                state;
    logic                  owner;       // 0 = instr, 1 = data
    logic                  last_grant;
    logic [15:0]           stall_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [3:0]            wstrb_q;
    logic                  mem_act_q;
    logic                  instr_ack_q;
    logic                  data_ack_q;
    logic [DATA_WIDTH-1:0] instr_rd_q;
    logic [DATA_WIDTH-1:0] data_rd_q;

    logic instr_req;
    logic data_req;
    logic pick_data;
    logic timeout_hit;

    always_comb begin
        instr_req   = bus.instr_cyc & bus.instr_stb;
        data_req    = bus.data_cyc & bus.data_stb;
        // data wins when alone, or on a tie when instr was granted last
        pick_data   = data_req & (~instr_req | ~last_grant);
        timeout_hit = (TIMEOUT_CYCLES != 0) && ((stall_cnt + 16'd1) == TO_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b0;
            stall_cnt   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= '0;
            mem_act_q   <= 1'b0;
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            instr_rd_q  <= '0;
            data_rd_q   <= '0;
            bus_err     <= 1'b0;
            err_src     <= 1'b0;
        end else begin
            instr_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        owner      <= pick_data;
                        last_grant <= pick_data;
                        addr_q     <= pick_data ? bus.data_addr     : bus.instr_addr;
                        wdata_q    <= pick_data ? bus.data_data_out : bus.instr_data_out;
                        we_q       <= pick_data ? bus.data_we       : bus.instr_we;
                        wstrb_q    <= pick_data ? bus.data_wstrb    : bus.instr_wstrb;
                        stall_cnt  <= '0;
                        mem_act_q  <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // a coincident mem_ack takes priority over timeout expiry
                    if (bus.mem_ack || timeout_hit) begin
                        if (owner) begin
                            data_rd_q  <= bus.mem_ack ? bus.mem_data_in : '0;
                            data_ack_q <= 1'b1;
                        end else begin
                            instr_rd_q  <= bus.mem_ack ? bus.mem_data_in : '0;
                            instr_ack_q <= 1'b1;
                        end
                        if (!bus.mem_ack) begin
                            bus_err <= 1'b1;
                            err_src <= owner;
                        end
                        mem_act_q <= 1'b0;
                        state     <= RESP;
                    end
                    if (!bus.mem_ack) stall_cnt <= stall_cnt + 16'd1;
                end
                RESP: state <= IDLE;
                default: begin
                    mem_act_q <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cyc       = mem_act_q;
    assign bus.mem_stb       = mem_act_q;
    assign bus.mem_we        = we_q;
    assign bus.mem_wstrb     = wstrb_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_data_out  = wdata_q;
    assign bus.instr_ack     = instr_ack_q;
    assign bus.data_ack      = data_ack_q;
    assign bus.instr_data_in = instr_rd_q;
    assign bus.data_data_in  = data_rd_q;
endmodule

// File: tb/tb_dual_bus_arbiter.sv
// Directed bench for dual_bus_arbiter: vector table for basic reads and round-robin ties,
// hand-written sequences for latching, timeout, ack/timeout race and mid-transaction reset.
module tb_dual_bus_arbiter;
    logic sys_clk = 1'b0;
    logic rst_n;
    logic bus_err;
    logic err_src;
    int   n_cmp  = 0;
    int   n_fail = 0;

    dual_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dual_bus_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk    (sys_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .bus_err(bus_err),
        .err_src(err_src)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        rst;
        logic        i_req;
        logic        d_req;
        logic        ack;
        logic [31:0] mdata;
        logic        e_stb;
        logic [31:0] e_addr;
        logic        e_iack;
        logic        e_dack;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t v(input logic rst, input logic i_req, input logic d_req,
                               input logic ack, input logic [31:0] mdata, input logic e_stb,
                               input logic [31:0] e_addr, input logic e_iack, input logic e_dack,
                               input logic [31:0] e_ird, input logic [31:0] e_drd);
        vec_t r;
        r.rst = rst; r.i_req = i_req; r.d_req = d_req; r.ack = ack; r.mdata = mdata;
        r.e_stb = e_stb; r.e_addr = e_addr; r.e_iack = e_iack; r.e_dack = e_dack;
        r.e_ird = e_ird; r.e_drd = e_drd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_cyc = 0; bus.instr_stb = 0; bus.instr_we = 0; bus.instr_wstrb = 4'h0;
        bus.instr_addr = 32'h0; bus.instr_data_out = 32'h0;
        bus.data_cyc = 0; bus.data_stb = 0; bus.data_we = 0; bus.data_wstrb = 4'h0;
        bus.data_addr = 32'h0; bus.data_data_out = 32'h0;
        bus.mem_ack = 0; bus.mem_data_in = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // instr read then mem_ack in IDLE, reset, four back-to-back tie rounds
        vecs[0]  = v(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,        32'h0);
        vecs[1]  = v(1, 1, 0, 1, 32'hCAFEF00D, 1, 32'h100, 0, 0, 32'h0,        32'h0);
        vecs[2]  = v(1, 0, 0, 0, 32'h0,        0, 32'h0,   1, 0, 32'hCAFEF00D, 32'h0);
        vecs[3]  = v(1, 0, 0, 1, 32'hDEAD0000, 0, 32'h0,   0, 0, 32'hCAFEF00D, 32'h0);
        vecs[4]  = v(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 32'hCAFEF00D, 32'h0);
        vecs[5]  = v(0, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 32'hCAFEF00D, 32'h0);
        vecs[6]  = v(1, 1, 1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,        32'h0);
        vecs[7]  = v(1, 1, 1, 1, 32'h11111111, 1, 32'h200, 0, 0, 32'h0,        32'h0);
        vecs[8]  = v(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 1, 32'h0,        32'h11111111);
        vecs[9]  = v(1, 1, 1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h0,        32'h11111111);
        vecs[10] = v(1, 1, 1, 1, 32'h22222222, 1, 32'h100, 0, 0, 32'h0,        32'h11111111);
        vecs[11] = v(1, 0, 1, 0, 32'h0,        0, 32'h0,   1, 0, 32'h22222222, 32'h11111111);
        vecs[12] = v(1, 1, 1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h22222222, 32'h11111111);
        vecs[13] = v(1, 1, 1, 1, 32'h33333333, 1, 32'h200, 0, 0, 32'h22222222, 32'h11111111);
        vecs[14] = v(1, 1, 0, 0, 32'h0,        0, 32'h0,   0, 1, 32'h22222222, 32'h33333333);
        vecs[15] = v(1, 1, 1, 0, 32'h0,        0, 32'h0,   0, 0, 32'h22222222, 32'h33333333);
        vecs[16] = v(1, 1, 1, 1, 32'h44444444, 1, 32'h100, 0, 0, 32'h22222222, 32'h33333333);
        vecs[17] = v(1, 0, 0, 0, 32'h0,        0, 32'h0,   1, 0, 32'h44444444, 32'h33333333);
        vecs[18] = v(1, 0, 0, 0, 32'h0,        0, 32'h0,   0, 0, 32'h44444444, 32'h33333333);

        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("rst_mem_cyc",   bus.mem_cyc, 0);
        chk("rst_mem_stb",   bus.mem_stb, 0);
        chk("rst_mem_we",    bus.mem_we, 0);
        chk("rst_mem_wstrb", bus.mem_wstrb, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_data_out, 0);
        chk("rst_iack",      bus.instr_ack, 0);
        chk("rst_dack",      bus.data_ack, 0);
        chk("rst_ird",       bus.instr_data_in, 0);
        chk("rst_drd",       bus.data_data_in, 0);
        chk("rst_bus_err",   bus_err, 0);
        chk("rst_err_src",   err_src, 0);
        next_cycle();

        bus.instr_addr = 32'h100;
        bus.data_addr  = 32'h200;
        for (int i = 0; i < 19; i++) begin
            rst_n           = vecs[i].rst;
            bus.instr_cyc   = vecs[i].i_req;
            bus.instr_stb   = vecs[i].i_req;
            bus.data_cyc    = vecs[i].d_req;
            bus.data_stb    = vecs[i].d_req;
            bus.mem_ack     = vecs[i].ack;
            bus.mem_data_in = vecs[i].mdata;
            @(negedge sys_clk);
            chk($sformatf("v%0d_stb", i),  bus.mem_stb, vecs[i].e_stb);
            chk($sformatf("v%0d_cyc", i),  bus.mem_cyc, vecs[i].e_stb);
            if (vecs[i].e_stb) chk($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_iack", i), bus.instr_ack, vecs[i].e_iack);
            chk($sformatf("v%0d_dack", i), bus.data_ack, vecs[i].e_dack);
            chk($sformatf("v%0d_ird", i),  bus.instr_data_in, vecs[i].e_ird);
            chk($sformatf("v%0d_drd", i),  bus.data_data_in, vecs[i].e_drd);
            chk($sformatf("v%0d_err", i),  bus_err, 0);
            next_cycle();
        end
        idle_inputs();
        rst_n = 1;

        // data write held stable while instr inputs churn without cyc
        bus.data_cyc = 1; bus.data_stb = 1; bus.data_we = 1; bus.data_wstrb = 4'h3;
        bus.data_addr = 32'h2000; bus.data_data_out = 32'h12345678;
        bus.instr_stb = 1;
        next_cycle();
        for (int c = 1; c <= 3; c++) begin
            bus.instr_addr     = $urandom;
            bus.instr_data_out = $urandom;
            bus.instr_wstrb    = 4'($urandom_range(0, 15));
            bus.instr_we       = 1'($urandom_range(0, 1));
            bus.mem_ack        = (c == 3);
            bus.mem_data_in    = 32'h0BADBEEF;
            @(negedge sys_clk);
            chk("wr_stb",   bus.mem_stb, 1);
            chk("wr_we",    bus.mem_we, 1);
            chk("wr_addr",  bus.mem_addr, 32'h2000);
            chk("wr_wdata", bus.mem_data_out, 32'h12345678);
            chk("wr_wstrb", bus.mem_wstrb, 4'h3);
            chk("wr_dack_busy", bus.data_ack, 0);
            next_cycle();
        end
        bus.mem_ack = 0;
        bus.data_cyc = 0; bus.data_stb = 0;
        @(negedge sys_clk);
        chk("wr_dack",  bus.data_ack, 1);
        chk("wr_iack",  bus.instr_ack, 0);
        chk("wr_stb_drop", bus.mem_stb, 0);
        chk("wr_drd",   bus.data_data_in, 32'h0BADBEEF);
        next_cycle();
        @(negedge sys_clk);
        chk("wr_idle_dack", bus.data_ack, 0);
        next_cycle();
        @(negedge sys_clk);
        chk("nocyc_no_grant", bus.mem_stb, 0);
        idle_inputs();
        next_cycle();

        // data read with no mem_ack: timeout after 8 BUSY cycles
        bus.data_cyc = 1; bus.data_stb = 1; bus.data_addr = 32'h300;
        next_cycle();
        for (int c = 1; c <= 8; c++) begin
            @(negedge sys_clk);
            chk($sformatf("to_stb_c%0d", c), bus.mem_stb, 1);
            chk($sformatf("to_err_c%0d", c), bus_err, 0);
            chk($sformatf("to_dack_c%0d", c), bus.data_ack, 0);
            next_cycle();
        end
        bus.data_cyc = 0; bus.data_stb = 0;
        @(negedge sys_clk);
        chk("to_stb_drop", bus.mem_stb, 0);
        chk("to_cyc_drop", bus.mem_cyc, 0);
        chk("to_bus_err",  bus_err, 1);
        chk("to_err_src",  err_src, 1);
        chk("to_dack",     bus.data_ack, 1);
        chk("to_iack",     bus.instr_ack, 0);
        chk("to_drd_zero", bus.data_data_in, 0);
        next_cycle();
        @(negedge sys_clk);
        chk("to_err_pulse", bus_err, 0);
        chk("to_src_hold",  err_src, 1);
        chk("to_dack_pulse", bus.data_ack, 0);
        next_cycle();

        // instr read acked on the 8th BUSY cycle: completion beats timeout
        bus.instr_cyc = 1; bus.instr_stb = 1; bus.instr_addr = 32'h400;
        next_cycle();
        for (int c = 1; c <= 8; c++) begin
            bus.mem_ack     = (c == 8);
            bus.mem_data_in = 32'hA5A55A5A;
            @(negedge sys_clk);
            chk($sformatf("race_stb_c%0d", c), bus.mem_stb, 1);
            next_cycle();
        end
        bus.mem_ack = 0;
        bus.instr_cyc = 0; bus.instr_stb = 0;
        @(negedge sys_clk);
        chk("race_iack", bus.instr_ack, 1);
        chk("race_ird",  bus.instr_data_in, 32'hA5A55A5A);
        chk("race_err",  bus_err, 0);
        chk("race_dack", bus.data_ack, 0);
        next_cycle();
        @(negedge sys_clk);
        chk("race_err_after", bus_err, 0);
        next_cycle();

        // reset for one cycle in BUSY abandons the request, even with mem_ack present
        bus.instr_cyc = 1; bus.instr_stb = 1; bus.instr_addr = 32'h440;
        next_cycle();
        @(negedge sys_clk);
        chk("mr_stb_busy", bus.mem_stb, 1);
        next_cycle();
        rst_n = 0;
        bus.mem_ack = 1; bus.mem_data_in = 32'hFFFF0000;
        next_cycle();
        rst_n = 1;
        bus.mem_ack = 0;
        bus.instr_cyc = 0; bus.instr_stb = 0;
        @(negedge sys_clk);
        chk("mr_stb",  bus.mem_stb, 0);
        chk("mr_iack", bus.instr_ack, 0);
        chk("mr_dack", bus.data_ack, 0);
        chk("mr_ird",  bus.instr_data_in, 0);
        chk("mr_src",  err_src, 0);
        next_cycle();
        @(negedge sys_clk);
        chk("mr_iack_later", bus.instr_ack, 0);
        bus.data_cyc = 1; bus.data_stb = 1; bus.data_addr = 32'h500;
        next_cycle();
        bus.mem_ack = 1; bus.mem_data_in = 32'h5A5A0001;
        @(negedge sys_clk);
        chk("mr_new_stb",  bus.mem_stb, 1);
        chk("mr_new_addr", bus.mem_addr, 32'h500);
        next_cycle();
        bus.mem_ack = 0;
        bus.data_cyc = 0; bus.data_stb = 0;
        @(negedge sys_clk);
        chk("mr_new_dack", bus.data_ack, 1);
        chk("mr_new_drd",  bus.data_data_in, 32'h5A5A0001);
        chk("mr_new_iack", bus.instr_ack, 0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
